// File: rtl/scoreboard_regfile.sv
// Integer register file with a per-register pending scoreboard and a sequential clear engine.
// Optional macro SCOREBOARD_BYPASS_EN forwards same-cycle writeback data and pending release to the read ports.
module scoreboard_regfile #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite,
  input  logic [AW-1:0]   WriteReg,
  input  logic [XLEN-1:0] WriteData,
  input  logic [AW-1:0]   ReadReg1,
  input  logic [AW-1:0]   ReadReg2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  input  logic            clear_req,
  output logic            clear_busy
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic [NREGS-1:1] pend;

  logic idle;
  logic wr_hit;
  logic wr_en;
  logic iss_en;

  assign idle   = (state == IDLE);
  assign wr_hit = RegWrite && (WriteReg != '0);
  // A clear request in IDLE discards the writeback and issue of that same cycle.
  assign wr_en  = idle && !clear_req && wr_hit;
  assign iss_en = idle && !clear_req && issue_valid && (issue_rd != '0);

  // NOTE: the storage array is reset because a mid-clear reset must leave the whole file zero;
  // a plain RAM macro could not be used here, which is acceptable for a small register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= FIRST_IDX;
      pend  <= '0;
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so the later pend set overrides the earlier clear.
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            idx   <= FIRST_IDX;
            pend  <= '0;
          end else begin
            if (wr_en) begin
              regs[WriteReg] <= WriteData;
              pend[WriteReg] <= 1'b0;
            end
            if (iss_en) begin
              pend[issue_rd] <= 1'b1;
            end
          end
        end
        CLEAR: begin
          regs[idx] <= '0;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= FIRST_IDX;
          end else begin
            idx <= idx + FIRST_IDX;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= FIRST_IDX;
        end
      endcase
    end
  end

  assign clear_busy = (state == CLEAR);

  // NOTE: every output gets a default first in always_comb so no latch can be inferred.
  always_comb begin
    ReadData1 = '0;
    busy1     = 1'b0;
    if (!idle) begin
      busy1 = 1'b1;
    end else if (ReadReg1 != '0) begin
      ReadData1 = regs[ReadReg1];
      busy1     = pend[ReadReg1];
`ifdef SCOREBOARD_BYPASS_EN
      if (wr_hit && (ReadReg1 == WriteReg)) begin
        ReadData1 = WriteData;
        busy1     = issue_valid && (issue_rd == WriteReg);
      end
`endif
    end
  end

  always_comb begin
    ReadData2 = '0;
    busy2     = 1'b0;
    if (!idle) begin
      busy2 = 1'b1;
    end else if (ReadReg2 != '0) begin
      ReadData2 = regs[ReadReg2];
      busy2     = pend[ReadReg2];
`ifdef SCOREBOARD_BYPASS_EN
      if (wr_hit && (ReadReg2 == WriteReg)) begin
        ReadData2 = WriteData;
        busy2     = issue_valid && (issue_rd == WriteReg);
      end
`endif
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed self-checking bench for scoreboard_regfile: default 32x32 build plus an AW=3, XLEN=16 build.
module tb_scoreboard_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        busy1, busy2;
  logic        clear_req;
  logic        clear_busy;

  logic        s_RegWrite;
  logic [2:0]  s_WriteReg;
  logic [15:0] s_WriteData;
  logic [2:0]  s_ReadReg1, s_ReadReg2;
  logic [15:0] s_ReadData1, s_ReadData2;
  logic        s_issue_valid;
  logic [2:0]  s_issue_rd;
  logic        s_busy1, s_busy2;
  logic        s_clear_req;
  logic        s_clear_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scoreboard_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .busy1      (busy1),
    .busy2      (busy2),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  scoreboard_regfile #(.XLEN(16), .AW(3)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (s_RegWrite),
    .WriteReg   (s_WriteReg),
    .WriteData  (s_WriteData),
    .ReadReg1   (s_ReadReg1),
    .ReadReg2   (s_ReadReg2),
    .ReadData1  (s_ReadData1),
    .ReadData2  (s_ReadData2),
    .issue_valid(s_issue_valid),
    .issue_rd   (s_issue_rd),
    .busy1      (s_busy1),
    .busy2      (s_busy2),
    .clear_req  (s_clear_req),
    .clear_busy (s_clear_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    issue_valid = 1'b0; issue_rd = '0; clear_req = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b0;
    idle_inputs();
    ReadReg1 = '0; ReadReg2 = '0;
    s_RegWrite = 1'b0; s_WriteReg = '0; s_WriteData = '0;
    s_ReadReg1 = '0; s_ReadReg2 = '0;
    s_issue_valid = 1'b0; s_issue_rd = '0; s_clear_req = 1'b0;

    // Reset state
    cyc(); cyc();
    settle();
    check("reset_clear_busy", {31'd0, clear_busy}, 32'd0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      settle();
      check("reset_rd1", ReadData1, 32'd0);
      check("reset_rd2", ReadData2, 32'd0);
      check("reset_busy", {30'd0, busy1, busy2}, 32'd0);
      #1;
    end
    check("reset_clear_busy_after", {31'd0, clear_busy}, 32'd0);

    // x0 is hardwired to zero
    cyc();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hDEADBEEF;
    cyc();
    idle_inputs(); ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    settle();
    check("x0_read", ReadData1, 32'd0);

    // Basic write then read on both ports
    cyc();
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h12345678;
    cyc();
    idle_inputs(); ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    settle();
    check("x5_rd1", ReadData1, 32'h12345678);
    check("x5_rd2", ReadData2, 32'h12345678);

    // Same-cycle read during write sees the old value without bypass
    cyc();
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hCAFEF00D;
    settle();
    check("x5_same_cycle_old", ReadData1, 32'h12345678);
    cyc();
    idle_inputs();
    settle();
    check("x5_next_cycle_new", ReadData1, 32'hCAFEF00D);

    // Scoreboard set on issue, cleared by writeback
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    idle_inputs(); ReadReg1 = 5'd7; ReadReg2 = 5'd5;
    settle();
    check("pend7_set", {31'd0, busy1}, 32'd1);
    check("pend5_clear", {31'd0, busy2}, 32'd0);
    cyc();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000077;
    settle();
    check("pend7_still_set_during_wb", {31'd0, busy1}, 32'd1);
    cyc();
    idle_inputs();
    settle();
    check("pend7_released", {31'd0, busy1}, 32'd0);
    check("x7_data", ReadData1, 32'h00000077);

    // Same register issued and written in one cycle: set wins
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd7;
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000777;
    cyc();
    idle_inputs();
    settle();
    check("pend7_set_wins", {31'd0, busy1}, 32'd1);
    check("x7_data_written", ReadData1, 32'h00000777);

    // Different registers in one cycle: both apply
    cyc();
    issue_valid = 1'b1; issue_rd = 5'd8;
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000007;
    cyc();
    idle_inputs(); ReadReg1 = 5'd7; ReadReg2 = 5'd8;
    settle();
    check("pend7_cleared_diff", {31'd0, busy1}, 32'd0);
    check("pend8_set_diff", {31'd0, busy2}, 32'd1);

    // Fill x1..x31 with their index, leave x3 pending, then clear
    for (int i = 1; i < 32; i++) begin
      cyc();
      RegWrite = 1'b1; WriteReg = 5'(i); WriteData = 32'(i);
    end
    cyc();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd3;
    cyc();
    idle_inputs(); ReadReg1 = 5'd31; ReadReg2 = 5'd3;
    settle();
    check("fill_x31", ReadData1, 32'd31);
    check("fill_x3", ReadData2, 32'd3);
    check("fill_x3_pending", {31'd0, busy2}, 32'd1);

    cyc();
    clear_req = 1'b1;
    RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'h0000AAAA;
    issue_valid = 1'b1; issue_rd = 5'd4;
    settle();
    check("clear_req_cycle_idle", {31'd0, clear_busy}, 32'd0);
    cyc();
    idle_inputs(); ReadReg1 = 5'd31; ReadReg2 = 5'd1;
    for (int n = 0; n < 31; n++) begin
      RegWrite = (n >= 2); WriteReg = 5'd1; WriteData = 32'hFFFF0000 | 32'(n);
      issue_valid = 1'b1; issue_rd = 5'd9;
      clear_req = (n == 5);
      settle();
      check("clear_busy_high", {31'd0, clear_busy}, 32'd1);
      check("clear_rd1_forced", ReadData1, 32'd0);
      check("clear_rd2_forced", ReadData2, 32'd0);
      check("clear_busy_forced", {30'd0, busy1, busy2}, 32'd3);
      cyc();
    end
    idle_inputs();
    settle();
    check("clear_done", {31'd0, clear_busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      settle();
      check("post_clear_rd1", ReadData1, 32'd0);
      check("post_clear_rd2", ReadData2, 32'd0);
      check("post_clear_busy", {30'd0, busy1, busy2}, 32'd0);
      #1;
    end
    // The clear must not retrigger from the request seen mid-clear
    cyc(); cyc();
    settle();
    check("no_retrigger", {31'd0, clear_busy}, 32'd0);

    // Reset in the middle of a clear
    cyc();
    RegWrite = 1'b1; WriteReg = 5'd20; WriteData = 32'h00002020;
    cyc();
    idle_inputs();
    issue_valid = 1'b1; issue_rd = 5'd21;
    cyc();
    idle_inputs(); ReadReg1 = 5'd20; ReadReg2 = 5'd21;
    settle();
    check("pre_abort_x20", ReadData1, 32'h00002020);
    check("pre_abort_pend21", {31'd0, busy2}, 32'd1);
    cyc();
    clear_req = 1'b1;
    cyc();
    idle_inputs();
    for (int n = 0; n < 10; n++) cyc();
    settle();
    check("mid_clear_busy", {31'd0, clear_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_clear_busy", {31'd0, clear_busy}, 32'd0);
    check("abort_x20", ReadData1, 32'd0);
    check("abort_pend21", {31'd0, busy2}, 32'd0);
    cyc();
    rst = 1'b1;
    RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'h0000600D;
    cyc();
    idle_inputs(); ReadReg1 = 5'd6; ReadReg2 = 5'd20;
    settle();
    check("after_abort_write", ReadData1, 32'h0000600D);
    check("after_abort_x20", ReadData2, 32'd0);

    // Small build: AW=3, XLEN=16
    for (int i = 1; i < 8; i++) begin
      cyc();
      s_RegWrite = 1'b1; s_WriteReg = 3'(i); s_WriteData = 16'h1000 + 16'(i);
    end
    cyc();
    s_RegWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_ReadReg1 = 3'(i); s_ReadReg2 = 3'(7 - i);
      settle();
      check("small_rd1", {16'd0, s_ReadData1}, (i == 0) ? 32'd0 : 32'h1000 + 32'(i));
      check("small_rd2", {16'd0, s_ReadData2}, (i == 7) ? 32'd0 : 32'h1000 + 32'(7 - i));
      #1;
    end
    cyc();
    s_clear_req = 1'b1;
    cyc();
    s_clear_req = 1'b0;
    cnt = 0;
    settle();
    while (s_clear_busy === 1'b1 && cnt < 20) begin
      cnt++;
      cyc();
      settle();
    end
    check("small_clear_len", 32'(cnt), 32'd7);
    s_ReadReg1 = 3'd7; s_ReadReg2 = 3'd1;
    #1;
    check("small_post_clear", {s_ReadData1, s_ReadData2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
